ram_stream_loader: RTL and testbench

- Initiator for the 2048x64 single-port internal RAM port (en/wr/addr/mask/wrData/rdData, 1-cycle read latency). Word addresses 0..1023 are boot ROM; 1024..2047 are writable.
- Converts byte-granular commands into RAM word accesses: writes pack an incoming byte stream into masked 64-bit writes; reads unpack RAM words into an outgoing byte stream.
- Sits between the debug/boot UART path and the internal RAM arbiter port.

---
 rtl/ram_loader_pkg.sv | 28 ++
 rtl/ram_word_packer.sv | 41 ++++
 rtl/ram_stream_loader.sv | 200 ++++++++++++++++++++
 tb/tb_ram_stream_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_loader_pkg.sv
// Shared types and helpers for the byte-stream <-> 64-bit RAM word loader.
package ram_loader_pkg;

    localparam int unsigned ADDR_W_DEF    = 11;
    localparam int unsigned ROM_WORDS_DEF = 1024;
    localparam int unsigned LEN_W_DEF     = ADDR_W_DEF + 3;

    typedef enum logic [2:0] {
        StIdle,
        StWfill,
        StWissue,
        StRreq,
        StRwait,
        StRsend,
        StFin
    } state_e;

    function automatic logic [7:0] lane_onehot(input logic [2:0] lane);
        logic [7:0] oh;
        oh = 8'h01 << lane;
        return oh;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [63:0] word, input logic [2:0] lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/ram_word_packer.sv
// Shared 64-bit lane buffer: accumulates masked write bytes, or holds a read word for unpacking.
module ram_word_packer
    import ram_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        put_byte,
    input  logic [2:0]  lane,
    input  logic [7:0]  byte_in,
    input  logic        load_word,
    input  logic [63:0] word_in,
    output logic [63:0] data,
    output logic [7:0]  mask,
    output logic [7:0]  byte_out
);

    logic [63:0] data_q;
    logic [7:0]  mask_q;

    // Clearing also zeroes the data so unfilled write lanes go out as zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q <= '0;
            mask_q <= '0;
        end else if (clear) begin
            data_q <= '0;
            mask_q <= '0;
        end else if (load_word) begin
            data_q <= word_in;
        end else if (put_byte) begin
            data_q[{lane, 3'b000} +: 8] <= byte_in;
            mask_q                      <= mask_q | lane_onehot(lane);
        end
    end

    assign data     = data_q;
    assign mask     = mask_q;
    assign byte_out = lane_byte(data_q, lane);

endmodule

// File: rtl/ram_stream_loader.sv
// Byte-stream loader for the internal 64-bit RAM port; writes below ROM_WORDS are suppressed.
// Optional running byte checksum on csum when RAM_LOADER_CHECKSUM_EN is defined.
module ram_stream_loader
    import ram_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned ROM_WORDS = ROM_WORDS_DEF,
    parameter int unsigned LEN_W     = ADDR_W + 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [LEN_W-1:0]  cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0]        m_data,
    output logic              ram_en,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_mask,
    output logic [63:0]       ram_wrData,
    input  logic [63:0]       ram_rdData,
    output logic              done,
    output logic              err,
    output logic [31:0]       csum
);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]  wword_q, wword_d;
    logic               err_q, err_d;

    logic [ADDR_W-1:0]  word;
    logic [2:0]         lane;
    logic               rom_hit;

    logic               pk_clear;
    logic               pk_put;
    logic               pk_load;
    logic [63:0]        pk_data;
    logic [7:0]         pk_mask;
    logic [7:0]         pk_byte;

    assign word    = addr_q[LEN_W-1:3];
    assign lane    = addr_q[2:0];
    assign rom_hit = 32'(wword_q) < ROM_WORDS;

    ram_word_packer u_packer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (pk_clear),
        .put_byte  (pk_put),
        .lane      (lane),
        .byte_in   (s_data),
        .load_word (pk_load),
        .word_in   (ram_rdData),
        .data      (pk_data),
        .mask      (pk_mask),
        .byte_out  (pk_byte)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            len_q   <= '0;
            wword_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wword_q <= wword_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        wword_d    = wword_q;
        err_d      = err_q;
        cmd_ready  = 1'b0;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        ram_en     = 1'b0;
        ram_wr     = 1'b0;
        ram_addr   = word;
        ram_mask   = '0;
        ram_wrData = '0;
        done       = 1'b0;
        pk_clear   = 1'b0;
        pk_put     = 1'b0;
        pk_load    = 1'b0;

        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d   = cmd_addr;
                    len_d    = cmd_len;
                    err_d    = 1'b0;
                    pk_clear = 1'b1;
                    if (cmd_len == '0) begin
                        state_d = StFin;
                    end else if (cmd_write) begin
                        state_d = StWfill;
                    end else begin
                        state_d = StRreq;
                    end
                end
            end
            StWfill: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    pk_put  = 1'b1;
                    // addr moves past the word once lane 7 fills, so remember the target.
                    wword_d = word;
                    addr_d  = addr_q + LEN_W'(1);
                    len_d   = len_q - LEN_W'(1);
                    if (lane == 3'd7 || len_q == LEN_W'(1)) begin
                        state_d = StWissue;
                    end
                end
            end
            StWissue: begin
                ram_addr = wword_q;
                if (rom_hit) begin
                    err_d = 1'b1;
                end else begin
                    ram_en     = 1'b1;
                    ram_wr     = 1'b1;
                    ram_mask   = pk_mask;
                    ram_wrData = pk_data;
                end
                pk_clear = 1'b1;
                state_d  = (len_q == '0) ? StFin : StWfill;
            end
            StRreq: begin
                ram_en  = 1'b1;
                state_d = StRwait;
            end
            StRwait: begin
                pk_load = 1'b1;
                state_d = StRsend;
            end
            StRsend: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    addr_d = addr_q + LEN_W'(1);
                    len_d  = len_q - LEN_W'(1);
                    if (len_q == LEN_W'(1)) begin
                        state_d = StFin;
                    end else if (lane == 3'd7) begin
                        state_d = StRreq;
                    end
                end
            end
            StFin: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign m_data = pk_byte;
    assign err    = err_q;

`ifdef RAM_LOADER_CHECKSUM_EN
    logic [31:0] csum_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else if (cmd_valid && cmd_ready) begin
            csum_q <= '0;
        end else if (s_valid && s_ready) begin
            csum_q <= csum_q + 32'(s_data);
        end else if (m_valid && m_ready) begin
            csum_q <= csum_q + 32'(m_data);
        end
    end

    assign csum = csum_q;
`else
    assign csum = '0;
`endif

endmodule

// File: tb/tb_ram_stream_loader.sv
// Self-checking bench for ram_stream_loader: directed vector table, hand sequences, random traffic.
module tb_ram_stream_loader;

    localparam int LW = 14;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [LW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    s_data;
    logic          m_valid;
    logic          m_ready;
    logic [7:0]    m_data;
    logic          ram_en;
    logic          ram_wr;
    logic [10:0]   ram_addr;
    logic [7:0]    ram_mask;
    logic [63:0]   ram_wrData;
    logic [63:0]   ram_rdData;
    logic          done;
    logic          err;
    logic [31:0]   csum;

    always #5 clk = ~clk;

    ram_stream_loader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .ram_en     (ram_en),
        .ram_wr     (ram_wr),
        .ram_addr   (ram_addr),
        .ram_mask   (ram_mask),
        .ram_wrData (ram_wrData),
        .ram_rdData (ram_rdData),
        .done       (done),
        .err        (err),
        .csum       (csum)
    );

    function automatic logic [63:0] init_word(input int w);
        logic [31:0] h;
        if (w == 0) return 64'h0807060504030201;
        if (w == 1) return 64'h100F0E0D0C0B0A09;
        h = 32'(w) * 32'h9E3779B1;
        return {h ^ 32'hA5A50F0F, h + 32'h13579BDF};
    endfunction

    // RAM model: single port, 1-cycle read latency, read data held until the next access.
    logic [63:0] mem [2048];
    logic [63:0] rd_q;
    logic [63:0] nw;
    logic        inited = 1'b0;
    assign ram_rdData = rd_q;

    always @(posedge clk) begin
        if (!inited) begin
            for (int w = 0; w < 2048; w++) mem[w] <= init_word(w);
            rd_q   <= '0;
            inited <= 1'b1;
        end else if (ram_en) begin
            if (ram_wr) begin
                nw = mem[ram_addr];
                for (int l = 0; l < 8; l++) begin
                    if (ram_mask[l]) nw[l*8 +: 8] = ram_wrData[l*8 +: 8];
                end
                mem[ram_addr] <= nw;
            end else begin
                rd_q <= mem[ram_addr];
            end
        end
    end

    typedef struct {
        logic        wr;
        logic [10:0] addr;
        logic [7:0]  mask;
        logic [63:0] data;
    } strobe_t;

    typedef struct {
        logic          wr;
        logic [LW-1:0] addr;
        logic [LW-1:0] len;
        logic [7:0]    b0;
        logic [7:0]    step;
        int            n_str;
        logic [10:0]   a0;
        logic [7:0]    m0;
        logic [63:0]   d0;
        logic [10:0]   a1;
        logic [7:0]    m1;
        logic [63:0]   d1;
        logic          err;
    } vec_t;

    logic [7:0] shadow [16384];
    logic [7:0] wq [$];
    logic [7:0] rq [$];
    strobe_t    sq [$];
    int         lat;
    int         dn;
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // mode 0: no stalls, 1: random stalls, 2: m_ready toggles 1,0,1,0...
    task automatic run_cmd(input logic wr, input logic [LW-1:0] a, input logic [LW-1:0] n,
                           input int mode);
        int         cyc;
        int         bi;
        int         lim;
        logic       prev_stall;
        logic [7:0] prev_data;
        rq.delete();
        sq.delete();
        lat = -1;
        dn  = 0;
        bi  = 0;
        cyc = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = n;
        while (!cmd_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        cmd_valid  = 1'b0;
        lim        = 20 * int'(n) + 40;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        for (cyc = 0; cyc < lim && lat < 0; cyc++) begin
            if (done) begin
                lat = cyc;
                dn++;
            end
            if (ram_en) sq.push_back('{ram_wr, ram_addr, ram_mask, ram_wrData});
            if (prev_stall) chk("m_hold", 64'({m_valid, m_data}), 64'({1'b1, prev_data}));
            s_valid = (bi < wq.size()) && (mode == 0 || $urandom_range(0, 3) != 0);
            s_data  = s_valid ? wq[bi] : 8'h00;
            if (s_valid && s_ready) bi++;
            if (mode == 0)      m_ready = 1'b1;
            else if (mode == 1) m_ready = ($urandom_range(0, 2) != 0);
            else                m_ready = (cyc % 2 == 0);
            if (m_valid && m_ready) rq.push_back(m_data);
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            @(negedge clk);
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("done_seen", 64'(lat >= 0), 64'(1));
        chk("done_pulse", 64'({done, 32'(dn)}), 64'({1'b0, 32'd1}));
        chk("bytes_consumed", 64'(bi), 64'(wr ? int'(n) : 0));
    endtask

    // Reference: walk byte addresses of the command and apply the byte-level rules.
    task automatic model_check(input logic wr, input logic [LW-1:0] a, input logic [LW-1:0] n,
                               input int mode, input string tag);
        int          nseg;
        int          nvis;
        int          wrong;
        int          wrong_dir;
        logic        exp_err;
        logic [31:0] sum;
        nseg    = 0;
        nvis    = 0;
        wrong   = 0;
        exp_err = 1'b0;
        sum     = '0;
        for (int i = 0; i < int'(n); i++) begin
            logic [LW-1:0] b;
            int            w;
            b = a + LW'(i);
            w = {21'b0, b[13:3]};
            if (wr) begin
                if (w < 1024) exp_err = 1'b1;
                else shadow[b] = wq[i];
                sum = sum + 32'(wq[i]);
                if (w >= 1024 && mem[b[13:3]][{b[2:0], 3'b000} +: 8] !== shadow[b]) wrong++;
            end else begin
                sum = sum + 32'(shadow[b]);
                if (i >= rq.size() || rq[i] !== shadow[b]) wrong++;
            end
            if (b[2:0] == 3'd7 || i == int'(n) - 1) begin
                nseg++;
                if (!wr || w >= 1024) nvis++;
            end
        end
        wrong_dir = 0;
        foreach (sq[k]) if (sq[k].wr !== wr) wrong_dir++;
        chk({tag, "_data"}, 64'(wrong), 64'(0));
        chk({tag, "_strobes"}, 64'(sq.size()), 64'(nvis));
        chk({tag, "_strobe_dir"}, 64'(wrong_dir), 64'(0));
        chk({tag, "_err"}, 64'(err), 64'(exp_err));
        if (!wr) chk({tag, "_rlen"}, 64'(rq.size()), 64'(int'(n)));
        if (mode == 0) chk({tag, "_latency"}, 64'(lat), 64'(int'(n) + (wr ? nseg : 2 * nseg)));
`ifdef RAM_LOADER_CHECKSUM_EN
        chk({tag, "_csum"}, 64'(csum), 64'(sum));
`else
        chk({tag, "_csum"}, 64'(csum), 64'(0));
`endif
    endtask

    vec_t vt [5];

    initial begin
        logic [7:0] acc;
        logic [63:0] iw;
        int cyc;
        int strobes;
        int dones;

        vt[0] = '{1'b1, 14'h2000, 14'd8, 8'h11, 8'h11, 1, 11'h400, 8'hFF, 64'h8877665544332211,
                  11'h000, 8'h00, 64'h0, 1'b0};
        vt[1] = '{1'b1, 14'h2005, 14'd5, 8'hA0, 8'h01, 2, 11'h400, 8'hE0, 64'hA2A1A00000000000,
                  11'h401, 8'h03, 64'h000000000000A4A3, 1'b0};
        vt[2] = '{1'b1, 14'h1FFC, 14'd8, 8'h01, 8'h01, 1, 11'h400, 8'h0F, 64'h0000000008070605,
                  11'h000, 8'h00, 64'h0, 1'b1};
        vt[3] = '{1'b1, 14'h2345, 14'd0, 8'h00, 8'h00, 0, 11'h000, 8'h00, 64'h0,
                  11'h000, 8'h00, 64'h0, 1'b0};
        vt[4] = '{1'b1, 14'h3FFE, 14'd4, 8'h31, 8'h01, 1, 11'h7FF, 8'hC0, 64'h3231000000000000,
                  11'h000, 8'h00, 64'h0, 1'b1};

        for (int w = 0; w < 2048; w++) begin
            iw = init_word(w);
            for (int l = 0; l < 8; l++) shadow[w*8 + l] = iw[l*8 +: 8];
        end

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        m_ready   = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_outputs",
            64'({cmd_ready, s_ready, m_valid, ram_en, ram_wr, ram_mask, done, err}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}));
        chk("rst_csum", 64'(csum), 64'(0));
        reset_n = 1'b1;

        // Directed vector table.
        for (int v = 0; v < 5; v++) begin
            wq.delete();
            acc = vt[v].b0;
            for (int i = 0; i < int'(vt[v].len); i++) begin
                wq.push_back(acc);
                acc = acc + vt[v].step;
            end
            run_cmd(vt[v].wr, vt[v].addr, vt[v].len, 0);
            model_check(vt[v].wr, vt[v].addr, vt[v].len, 0, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_err_tab", v), 64'(err), 64'(vt[v].err));
            chk($sformatf("vec%0d_nstr", v), 64'(sq.size()), 64'(vt[v].n_str));
            for (int k = 0; k < vt[v].n_str; k++) begin
                if (k < sq.size()) begin
                    chk($sformatf("vec%0d_s%0d_addr", v, k), 64'(sq[k].addr),
                        64'(k == 0 ? vt[v].a0 : vt[v].a1));
                    chk($sformatf("vec%0d_s%0d_mask", v, k), 64'(sq[k].mask),
                        64'(k == 0 ? vt[v].m0 : vt[v].m1));
                    chk($sformatf("vec%0d_s%0d_data", v, k), sq[k].data,
                        k == 0 ? vt[v].d0 : vt[v].d1);
                end
            end
`ifdef RAM_LOADER_CHECKSUM_EN
            if (v == 0) chk("vec0_csum_const", 64'(csum), 64'h264);
`endif
        end

        // Read across a word boundary with m_ready toggling.
        wq.delete();
        run_cmd(1'b0, 14'h0003, 14'd6, 2);
        model_check(1'b0, 14'h0003, 14'd6, 2, "rd_toggle");
        chk("rd_toggle_nstr", 64'(sq.size()), 64'(2));
        if (sq.size() >= 2) chk("rd_toggle_addrs", 64'({sq[0].addr, sq[1].addr}), 64'({11'd0, 11'd1}));
        if (rq.size() == 6) chk("rd_toggle_ends", 64'({rq[0], rq[5]}), 64'({8'h04, 8'h09}));

        // Reset while a read byte is being offered.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 14'h2010;
        cmd_len   = 14'd4;
        @(negedge clk);
        cmd_valid = 1'b0;
        m_ready   = 1'b0;
        cyc = 0;
        while (!m_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_mid_pre_mvalid", 64'(m_valid), 64'(1));
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs", 64'({m_valid, cmd_ready, ram_en, done}),
            64'({1'b0, 1'b1, 1'b0, 1'b0}));
        reset_n = 1'b1;
        strobes = 0;
        dones   = 0;
        repeat (8) begin
            @(negedge clk);
            if (ram_en) strobes++;
            if (done) dones++;
        end
        chk("rst_mid_quiet", 64'({32'(strobes), 32'(dones)}), 64'(0));

        // Random traffic against the byte-level model.
        for (int t = 0; t < 40; t++) begin
            logic          rwr;
            logic [LW-1:0] ra;
            logic [LW-1:0] rn;
            rwr = 1'($urandom_range(0, 1));
            ra  = ($urandom_range(0, 3) == 0) ? LW'($urandom) : LW'(14'h2000 + 14'($urandom_range(0, 8191)));
            rn  = LW'($urandom_range(0, 20));
            wq.delete();
            for (int i = 0; i < int'(rn); i++) wq.push_back(8'($urandom));
            run_cmd(rwr, ra, rn, 1);
            model_check(rwr, ra, rn, 1, $sformatf("rnd%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
